// File: rtl/wb_master_arbiter_if.sv
// Wishbone bundle between two requesting masters, the arbiter and one RAM slave.
// The master modport is the arbiter's own view: it masters the RAM side and
// answers the two requesters. The slave modport is the environment's view.
interface wb_master_arbiter_if;
  // requester side, bit/slice i belongs to master i
  logic [1:0]  m_CYC;
  logic [1:0]  m_STB;
  logic [1:0]  m_LOCK;
  logic [1:0]  m_WE;
  logic [7:0]  m_SEL;
  logic [63:0] m_ADR;
  logic [63:0] m_DAT_W;
  logic [31:0] m_DAT_R;
  logic [1:0]  m_ACK;
  logic [1:0]  m_ERR;
  // RAM side
  logic        s_CYC;
  logic        s_STB;
  logic        s_LOCK;
  logic        s_WE;
  logic [3:0]  s_SEL;
  logic [31:0] s_ADR;
  logic [31:0] s_DAT_O;
  logic [31:0] s_DAT_I;
  logic        s_ACK_I;
  logic        s_ERR_I;

  modport master (
    input  m_CYC, m_STB, m_LOCK, m_WE, m_SEL, m_ADR, m_DAT_W,
    output m_DAT_R, m_ACK, m_ERR,
    output s_CYC, s_STB, s_LOCK, s_WE, s_SEL, s_ADR, s_DAT_O,
    input  s_DAT_I, s_ACK_I, s_ERR_I
  );

  modport slave (
    output m_CYC, m_STB, m_LOCK, m_WE, m_SEL, m_ADR, m_DAT_W,
    input  m_DAT_R, m_ACK, m_ERR,
    input  s_CYC, s_STB, s_LOCK, s_WE, s_SEL, s_ADR, s_DAT_O,
    output s_DAT_I, s_ACK_I, s_ERR_I
  );
endinterface

// File: rtl/wb_master_arbiter.sv
// Two-master Wishbone arbiter in front of a single RAM slave.
// Master 0 is the frame-capture writer, master 1 the video fetch reader.
// Ownership is granted per CYC/LOCK tenure (round-robin or fixed priority),
// the data path is a transparent mux, and a watchdog aborts a strobe the
// slave never answers so one requester cannot hang the shared bus.
module wb_master_arbiter #(
  parameter int TIMEOUT = 256,
  parameter bit RR_EN   = 1'b1
) (
  input  logic              clk,
  input  logic              nRST,
  wb_master_arbiter_if.master bus,
  output logic [1:0]        grant
);

  localparam int WD_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2
  } state_t;

  state_t            state;
  logic              last;      // index of the previous owner
  logic [WD_W-1:0]   wdog;

  logic              g;         // index of the current owner
  logic              busy;
  logic              stall;
  logic              timeout_hit;

  logic              s_cyc;
  logic              s_stb;
  logic              s_lock;
  logic              s_we;
  logic [3:0]        s_sel;
  logic [31:0]       s_adr;
  logic [31:0]       s_dat_o;
  logic [1:0]        m_ack;
  logic [1:0]        m_err;
  logic [31:0]       m_dat_r;

  // One-hot winner among the requesters; ties go away from the last owner
  // in round-robin mode and to master 0 in fixed-priority mode.
  function automatic logic [1:0] pick_winner(input logic [1:0] cyc, input logic prev);
    logic [1:0] win;
    case (cyc)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11: begin
        if (RR_EN) begin
          win = prev ? 2'b01 : 2'b10;
        end else begin
          win = 2'b01;
        end
      end
      default: win = 2'b00;
    endcase
    return win;
  endfunction

  // Saturating increment so the watchdog never wraps back to zero.
  function automatic logic [WD_W-1:0] sat_inc(input logic [WD_W-1:0] v);
    logic [WD_W-1:0] r;
    if (v == {WD_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(WD_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  assign g           = grant[1];
  assign busy        = (state == BUSY);
  assign stall       = busy & s_stb & ~bus.s_ACK_I & ~bus.s_ERR_I;
  assign timeout_hit = stall & (wdog == WD_W'(TIMEOUT - 1));

  // Route the owner's request to the slave and the slave's reply to the owner.
  always_comb begin
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_lock  = 1'b0;
    s_we    = 1'b0;
    s_sel   = 4'h0;
    s_adr   = 32'h0000_0000;
    s_dat_o = 32'h0000_0000;
    m_ack   = 2'b00;
    m_err   = 2'b00;
    m_dat_r = 32'h0000_0000;
    if (busy) begin
      s_cyc   = bus.m_CYC[g];
      s_stb   = bus.m_STB[g];
      s_lock  = bus.m_LOCK[g];
      s_we    = bus.m_WE[g];
      s_sel   = g ? bus.m_SEL[7:4]    : bus.m_SEL[3:0];
      s_adr   = g ? bus.m_ADR[63:32]  : bus.m_ADR[31:0];
      s_dat_o = g ? bus.m_DAT_W[63:32] : bus.m_DAT_W[31:0];
      m_dat_r = bus.s_DAT_I;
      if (g) begin
        m_ack = {bus.s_ACK_I, 1'b0};
        m_err = {bus.s_ERR_I | timeout_hit, 1'b0};
      end else begin
        m_ack = {1'b0, bus.s_ACK_I};
        m_err = {1'b0, bus.s_ERR_I | timeout_hit};
      end
    end else begin
      // idle and abort both keep the slave and the requesters quiet
      s_cyc   = 1'b0;
      s_stb   = 1'b0;
      m_ack   = 2'b00;
      m_err   = 2'b00;
    end
  end

  assign bus.s_CYC   = s_cyc;
  assign bus.s_STB   = s_stb;
  assign bus.s_LOCK  = s_lock;
  assign bus.s_WE    = s_we;
  assign bus.s_SEL   = s_sel;
  assign bus.s_ADR   = s_adr;
  assign bus.s_DAT_O = s_dat_o;
  assign bus.m_ACK   = m_ack;
  assign bus.m_ERR   = m_err;
  assign bus.m_DAT_R = m_dat_r;

  // Ownership FSM with the unanswered-strobe watchdog.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      grant <= 2'b00;
      last  <= 1'b1;
      wdog  <= '0;
    end else begin
      case (state)
        IDLE: begin
          wdog <= '0;
          if (|bus.m_CYC) begin
            grant <= pick_winner(bus.m_CYC, last);
            state <= BUSY;
          end
        end
        BUSY: begin
          if (timeout_hit) begin
            // the error pulse goes out this cycle, the tenure is torn down next
            wdog  <= '0;
            state <= ABORT;
          end else begin
            wdog <= stall ? sat_inc(wdog) : '0;
            if (!(bus.m_CYC[g] | bus.m_LOCK[g])) begin
              last  <= g;
              grant <= 2'b00;
              state <= IDLE;
            end
          end
        end
        ABORT: begin
          wdog <= '0;
          if (!bus.m_CYC[g] && !bus.m_LOCK[g]) begin
            last  <= g;
            grant <= 2'b00;
            state <= IDLE;
          end
        end
        default: begin
          wdog  <= '0;
          grant <= 2'b00;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed bench for wb_master_arbiter: a cycle table for the main tenure
// behaviour, plus hand sequences for arbitration order, watchdog and reset.
module tb_wb_master_arbiter;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic [1:0] grant_a;
  logic [1:0] grant_b;
  logic       auto_ack_a = 1'b0;
  logic       ack_a = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;

  wb_master_arbiter_if bus_a ();
  wb_master_arbiter_if bus_b ();

  // slave models: A is scripted or zero-wait, B is always zero-wait
  assign bus_a.s_ACK_I = auto_ack_a ? bus_a.s_STB : ack_a;
  assign bus_b.s_ACK_I = bus_b.s_STB;

  wb_master_arbiter #(.TIMEOUT(16), .RR_EN(1'b1)) dut_a (
    .clk(clk), .nRST(nrst), .bus(bus_a), .grant(grant_a)
  );

  wb_master_arbiter #(.TIMEOUT(16), .RR_EN(1'b0)) dut_b (
    .clk(clk), .nRST(nrst), .bus(bus_b), .grant(grant_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] cyc;    // STB follows CYC
    logic [1:0] lock;
    logic       ack;
    logic       err;
    logic [1:0] e_gnt;
    logic       e_scyc;
    logic       e_sstb;
    logic       e_slock;
    logic [1:0] e_ack;
    logic [1:0] e_err;
  } vec_t;

  vec_t tbl [24];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    bus_a.m_CYC = 2'b00; bus_a.m_STB = 2'b00; bus_a.m_LOCK = 2'b00;
    bus_b.m_CYC = 2'b00; bus_b.m_STB = 2'b00;
    ack_a = 1'b0; auto_ack_a = 1'b0; bus_a.s_ERR_I = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;
  endtask

  task automatic drive_req(input bit fixed, input logic [1:0] cyc);
    if (fixed) begin
      bus_b.m_CYC = cyc;
      bus_b.m_STB = cyc;
    end else begin
      bus_a.m_CYC = cyc;
      bus_a.m_STB = cyc;
    end
  endtask

  // Both masters issue three single zero-wait transfers back to back;
  // exp_seq lists the six expected owners, first one in the top bits.
  task automatic run_rr(input bit fixed, input logic [11:0] exp_seq);
    logic [1:0] cyc, pend, drop, g, ack, prev;
    logic [1:0] rec [6];
    int done [2];
    int nrec;
    cyc = 2'b11; pend = 2'b00; prev = 2'b00; nrec = 0;
    done[0] = 0; done[1] = 0;
    for (int j = 0; j < 6; j++) rec[j] = 2'b00;
    drive_req(fixed, cyc);
    for (int c = 0; c < 80 && !(done[0] == 3 && done[1] == 3); c++) begin
      @(negedge clk);
      g   = fixed ? grant_b : grant_a;
      ack = fixed ? bus_b.m_ACK : bus_a.m_ACK;
      if (g != 2'b00 && prev == 2'b00) begin
        if (nrec < 6) rec[nrec] = g;
        nrec++;
      end
      prev = g;
      drop = ack;
      for (int i = 0; i < 2; i++) if (ack[i]) done[i]++;
      step();
      for (int i = 0; i < 2; i++) if (pend[i] && done[i] < 3) cyc[i] = 1'b1;
      cyc  = cyc & ~drop;
      pend = drop;
      drive_req(fixed, cyc);
    end
    check(fixed ? "fp_tenures" : "rr_tenures", 64'(nrec), 64'd6);
    for (int j = 0; j < 6; j++)
      check($sformatf("%s_grant[%0d]", fixed ? "fp" : "rr", j), 64'(rec[j]), 64'(exp_seq[11-2*j -: 2]));
    drive_req(fixed, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    logic [31:0] adr0, adr1, dat0, dat1, sdat, e_adr, e_dat;
    logic [3:0]  e_sel;
    logic        e_we;

    //                cyc    lock   ack   err  | gnt  scyc  sstb  slock ack    err
    tbl[0]  = '{2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
    tbl[1]  = '{2'b11, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
    tbl[2]  = '{2'b11, 2'b00, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 2'b01, 2'b00};
    tbl[3]  = '{2'b11, 2'b00, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 2'b01, 2'b00};
    tbl[4]  = '{2'b11, 2'b00, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 2'b01, 2'b00};
    tbl[5]  = '{2'b11, 2'b00, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 2'b01, 2'b00};
    tbl[6]  = '{2'b10, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
    tbl[7]  = '{2'b10, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
    tbl[8]  = '{2'b10, 2'b00, 1'b0, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 2'b00, 2'b10};
    tbl[9]  = '{2'b10, 2'b00, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 2'b10, 2'b00};
    tbl[10] = '{2'b01, 2'b10, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00};
    tbl[11] = '{2'b01, 2'b10, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00};
    tbl[12] = '{2'b11, 2'b10, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 1'b1, 2'b10, 2'b00};
    tbl[13] = '{2'b01, 2'b00, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
    tbl[14] = '{2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
    tbl[15] = '{2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
    tbl[16] = '{2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
    tbl[17] = '{2'b11, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
    tbl[18] = '{2'b11, 2'b00, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 2'b10, 2'b00};
    tbl[19] = '{2'b01, 2'b00, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
    tbl[20] = '{2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
    tbl[21] = '{2'b01, 2'b00, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 2'b01, 2'b00};
    tbl[22] = '{2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
    tbl[23] = '{2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};

    bus_a.m_WE = 2'b01; bus_a.m_SEL = 8'hC3;
    bus_a.m_ADR = 64'h0; bus_a.m_DAT_W = 64'h0; bus_a.s_DAT_I = 32'h0; bus_a.s_ERR_I = 1'b0;
    bus_b.m_WE = 2'b00; bus_b.m_SEL = 8'h00; bus_b.m_LOCK = 2'b00;
    bus_b.m_ADR = 64'h0; bus_b.m_DAT_W = 64'h0; bus_b.s_DAT_I = 32'h0; bus_b.s_ERR_I = 1'b0;

    // reset state
    do_reset();
    @(negedge clk);
    check("reset_ctl", {grant_a, bus_a.s_CYC, bus_a.s_STB, bus_a.m_ACK, bus_a.m_ERR}, 64'h0);
    check("reset_dat", {bus_a.s_ADR, bus_a.m_DAT_R}, 64'h0);

    // cycle table: tenure, burst, error forward, lock hold, early CYC drop
    for (int i = 0; i < 24; i++) begin
      step();
      adr0 = 32'h1000_0000 + 32'(i * 4);
      adr1 = 32'h2000_0000 + 32'(i * 4);
      dat0 = 32'hA000_0000 + 32'(i);
      dat1 = 32'hB000_0000 + 32'(i);
      sdat = 32'hD000_0000 + 32'(i);
      bus_a.m_CYC   = tbl[i].cyc;
      bus_a.m_STB   = tbl[i].cyc;
      bus_a.m_LOCK  = tbl[i].lock;
      bus_a.m_ADR   = {adr1, adr0};
      bus_a.m_DAT_W = {dat1, dat0};
      bus_a.s_DAT_I = sdat;
      bus_a.s_ERR_I = tbl[i].err;
      ack_a         = tbl[i].ack;
      e_adr = (tbl[i].e_gnt == 2'b01) ? adr0 : (tbl[i].e_gnt == 2'b10) ? adr1 : 32'h0;
      e_dat = (tbl[i].e_gnt == 2'b01) ? dat0 : (tbl[i].e_gnt == 2'b10) ? dat1 : 32'h0;
      e_sel = (tbl[i].e_gnt == 2'b01) ? 4'h3 : (tbl[i].e_gnt == 2'b10) ? 4'hC : 4'h0;
      e_we  = (tbl[i].e_gnt == 2'b01);
      @(negedge clk);
      check($sformatf("row%0d_ctl", i),
            {grant_a, bus_a.s_CYC, bus_a.s_STB, bus_a.s_LOCK, bus_a.m_ACK, bus_a.m_ERR},
            {tbl[i].e_gnt, tbl[i].e_scyc, tbl[i].e_sstb, tbl[i].e_slock, tbl[i].e_ack, tbl[i].e_err});
      check($sformatf("row%0d_adr", i), bus_a.s_ADR, e_adr);
      check($sformatf("row%0d_dat", i), {bus_a.s_DAT_O, bus_a.m_DAT_R},
            {e_dat, (tbl[i].e_gnt != 2'b00) ? sdat : 32'h0});
      check($sformatf("row%0d_sel_we", i), {bus_a.s_SEL, bus_a.s_WE}, {e_sel, e_we});
    end

    // arbitration order: round-robin on A, fixed priority on B
    do_reset();
    auto_ack_a = 1'b1;
    run_rr(1'b0, 12'b01_10_01_10_01_10);
    auto_ack_a = 1'b0;
    run_rr(1'b1, 12'b01_01_01_10_10_10);

    // watchdog: slave never answers, error on the 16th strobe cycle
    do_reset();
    bus_a.s_ERR_I = 1'b0;
    drive_req(1'b0, 2'b01);
    step();
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check($sformatf("wd_err[%0d]", k), {grant_a, bus_a.s_CYC, bus_a.m_ERR},
            {2'b01, 1'b1, (k == 16) ? 2'b01 : 2'b00});
      step();
    end
    @(negedge clk);
    check("wd_abort", {grant_a, bus_a.s_CYC, bus_a.s_STB, bus_a.m_ERR}, {2'b01, 1'b0, 1'b0, 2'b00});
    step();
    @(negedge clk);
    check("wd_hold", grant_a, 2'b01);
    step();
    drive_req(1'b0, 2'b00);
    @(negedge clk);
    check("wd_hold_last", grant_a, 2'b01);
    step();
    @(negedge clk);
    check("wd_release", grant_a, 2'b00);

    // watchdog boundary: ACK on the 16th strobe cycle wins, no abort
    drive_req(1'b0, 2'b01);
    step();
    for (int k = 1; k <= 16; k++) begin
      ack_a = (k == 16);
      @(negedge clk);
      if (k == 16)
        check("wd_ack_wins", {bus_a.m_ACK, bus_a.m_ERR}, {2'b01, 2'b00});
      step();
    end
    ack_a = 1'b0;
    @(negedge clk);
    check("wd_no_abort", {grant_a, bus_a.s_CYC, bus_a.m_ERR}, {2'b01, 1'b1, 2'b00});
    drive_req(1'b0, 2'b00);
    repeat (2) step();

    // asynchronous reset in the middle of a transfer
    do_reset();
    ack_a = 1'b1;
    bus_a.s_DAT_I = 32'h5A5A_1234;
    drive_req(1'b0, 2'b01);
    step();
    @(negedge clk);
    check("mid_busy", {grant_a, bus_a.m_ACK}, {2'b01, 2'b01});
    #2;
    nrst = 1'b0;
    #1;
    check("mid_reset_outs", {grant_a, bus_a.s_CYC, bus_a.s_STB, bus_a.m_ACK, bus_a.m_ERR}, 64'h0);
    check("mid_reset_dat", {bus_a.s_ADR, bus_a.m_DAT_R}, 64'h0);
    step();
    nrst = 1'b1;
    ack_a = 1'b0;
    bus_a.m_ADR = {32'h2222_0000, 32'h1111_0000};
    drive_req(1'b0, 2'b11);
    @(negedge clk);
    check("post_reset_idle", grant_a, 2'b00);
    step();
    @(negedge clk);
    check("post_reset_grant", {grant_a, bus_a.s_ADR}, {2'b01, 32'h1111_0000});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
